// File: rtl/lanectrl_pkg.sv
// Shared types and widths for the lane-controller pause sequencer.
package lanectrl_pkg;

  localparam int PHASE_W = 8;
  localparam int STAT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEAD = 3'd1,
    ST_MOVE = 3'd2,
    ST_GAP  = 3'd3,
    ST_TAIL = 3'd4,
    ST_DONE = 3'd5
  } seq_state_e;

endpackage

// File: rtl/lanectrl_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Loading N-1 therefore yields a phase of exactly N cycles.
module lanectrl_phase_timer
  import lanectrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  output logic               done
);

  logic [PHASE_W-1:0] cnt_q;
  logic [PHASE_W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {PHASE_W{1'b0}}) begin
      cnt_d = cnt_q - PHASE_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {PHASE_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == {PHASE_W{1'b0}});

endmodule

// File: rtl/lanectrl_pause_sequencer.sv
// Holds HS_IO_CLK_PAUSE around a train of delay-line move pulses.
// Optional counters: define LANECTRL_PAUSE_SEQ_STATS_EN to add STAT_* ports.
module lanectrl_pause_sequencer
  import lanectrl_pkg::*;
#(
  parameter int LEAD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int TAIL_CYCLES = 4,
  parameter int TAP_W       = 7
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             UPD_REQ,
  input  logic             UPD_DIR,
  input  logic [TAP_W-1:0] UPD_TAPS,
  input  logic             DELAY_OOR,
`ifdef LANECTRL_PAUSE_SEQ_STATS_EN
  input  logic              STAT_CLR,
  output logic [STAT_W-1:0] STAT_UPDATES,
  output logic [STAT_W-1:0] STAT_ABORTS,
`endif
  output logic             UPD_ACK,
  output logic             UPD_ABORT,
  output logic             BUSY,
  output logic             HS_IO_CLK_PAUSE,
  output logic             DELAY_MOVE,
  output logic             DELAY_DIR
);

  localparam logic [PHASE_W-1:0] LEAD_LD = PHASE_W'(LEAD_CYCLES - 1);
  localparam logic [PHASE_W-1:0] TAIL_LD = PHASE_W'(TAIL_CYCLES - 1);
  localparam logic [PHASE_W-1:0] GAP_LD  = PHASE_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  seq_state_e         state_q, state_d;
  logic [TAP_W-1:0]   taps_q, taps_d;
  logic               dir_q, dir_d;
  logic               abort_flag_q, abort_flag_d;
  logic               pause_q, pause_d;
  logic               move_q, move_d;
  logic               ack_q, ack_d;
  logic               upd_abort_q, upd_abort_d;
  logic               busy_q, busy_d;
  logic               tmr_load_s;
  logic [PHASE_W-1:0] tmr_val_s;
  logic               tmr_done_s;

  lanectrl_phase_timer u_timer (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .done     (tmr_done_s)
  );

  // Sequencing: each phase-timed state loads the timer on entry.
  always_comb begin
    state_d      = state_q;
    taps_d       = taps_q;
    dir_d        = dir_q;
    abort_flag_d = abort_flag_q;
    tmr_load_s   = 1'b0;
    tmr_val_s    = LEAD_LD;
    case (state_q)
      ST_IDLE: begin
        if (UPD_REQ) begin
          state_d      = ST_LEAD;
          dir_d        = UPD_DIR;
          taps_d       = UPD_TAPS;
          abort_flag_d = 1'b0;
          tmr_load_s   = 1'b1;
          tmr_val_s    = LEAD_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEAD: begin
        if (!tmr_done_s) begin
          state_d = ST_LEAD;
        end else if (taps_q == {TAP_W{1'b0}}) begin
          state_d    = ST_TAIL;
          tmr_load_s = 1'b1;
          tmr_val_s  = TAIL_LD;
        end else begin
          state_d = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (taps_q != {TAP_W{1'b0}}) begin
          taps_d = taps_q - TAP_W'(1);
        end else begin
          taps_d = taps_q;
        end
        // OOR also sets the abort flag on the final pulse: the IOD saw the limit.
        if (DELAY_OOR) begin
          state_d      = ST_TAIL;
          abort_flag_d = 1'b1;
          tmr_load_s   = 1'b1;
          tmr_val_s    = TAIL_LD;
        end else if (taps_q <= TAP_W'(1)) begin
          state_d    = ST_TAIL;
          tmr_load_s = 1'b1;
          tmr_val_s  = TAIL_LD;
        end else if (GAP_CYCLES > 0) begin
          state_d    = ST_GAP;
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LD;
        end else begin
          state_d = ST_MOVE;
        end
      end
      ST_GAP: begin
        if (DELAY_OOR) begin
          state_d      = ST_TAIL;
          abort_flag_d = 1'b1;
          tmr_load_s   = 1'b1;
          tmr_val_s    = TAIL_LD;
        end else if (tmr_done_s) begin
          state_d = ST_MOVE;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_TAIL: begin
        if (tmr_done_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_TAIL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    pause_d     = (state_d == ST_LEAD) || (state_d == ST_MOVE) ||
                  (state_d == ST_GAP)  || (state_d == ST_TAIL);
    move_d      = (state_d == ST_MOVE);
    ack_d       = (state_d == ST_DONE);
    upd_abort_d = (state_d == ST_DONE) && abort_flag_d;
    busy_d      = (state_d != ST_IDLE);
  end

  // State, captured request and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      taps_q       <= {TAP_W{1'b0}};
      dir_q        <= 1'b0;
      abort_flag_q <= 1'b0;
      pause_q      <= 1'b0;
      move_q       <= 1'b0;
      ack_q        <= 1'b0;
      upd_abort_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      taps_q       <= taps_d;
      dir_q        <= dir_d;
      abort_flag_q <= abort_flag_d;
      pause_q      <= pause_d;
      move_q       <= move_d;
      ack_q        <= ack_d;
      upd_abort_q  <= upd_abort_d;
      busy_q       <= busy_d;
    end
  end

  assign UPD_ACK         = ack_q;
  assign UPD_ABORT       = upd_abort_q;
  assign BUSY            = busy_q;
  assign HS_IO_CLK_PAUSE = pause_q;
  assign DELAY_MOVE      = move_q;
  assign DELAY_DIR       = dir_q;

`ifdef LANECTRL_PAUSE_SEQ_STATS_EN
  logic [STAT_W-1:0] stat_upd_q, stat_upd_d;
  logic [STAT_W-1:0] stat_abt_q, stat_abt_d;

  // Saturating counters; clear beats increment.
  always_comb begin
    stat_upd_d = stat_upd_q;
    stat_abt_d = stat_abt_q;
    if (STAT_CLR) begin
      stat_upd_d = {STAT_W{1'b0}};
      stat_abt_d = {STAT_W{1'b0}};
    end else begin
      if (ack_d && (stat_upd_q != {STAT_W{1'b1}})) begin
        stat_upd_d = stat_upd_q + STAT_W'(1);
      end else begin
        stat_upd_d = stat_upd_q;
      end
      if (upd_abort_d && (stat_abt_q != {STAT_W{1'b1}})) begin
        stat_abt_d = stat_abt_q + STAT_W'(1);
      end else begin
        stat_abt_d = stat_abt_q;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stat_upd_q <= {STAT_W{1'b0}};
      stat_abt_q <= {STAT_W{1'b0}};
    end else begin
      stat_upd_q <= stat_upd_d;
      stat_abt_q <= stat_abt_d;
    end
  end

  assign STAT_UPDATES = stat_upd_q;
  assign STAT_ABORTS  = stat_abt_q;
`endif

endmodule
